// File: rtl/spi_bus_pkg.sv
// Shared types and constants for the SPI bus arbiter slice.
package spi_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN_MEM,
    ARB_OWN_PERIPH,
    ARB_GAP
  } arb_state_t;

  localparam int unsigned SPI_NUM_PCS        = 6;
  localparam int unsigned SPI_GAP_DEFAULT    = 2;
  localparam int unsigned SPI_STARVE_DEFAULT = 64;
  localparam int unsigned SPI_GAP_W          = 4;
  localparam int unsigned SPI_STARVE_W       = 8;

endpackage

// File: rtl/spi_starve_counter.sv
// Saturating wait counter for the peripheral master; flag is high while saturated.
module spi_starve_counter
  import spi_bus_pkg::*;
#(
  parameter int unsigned LIMIT = SPI_STARVE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic flag
);

  localparam logic [SPI_STARVE_W-1:0] LIMIT_V = SPI_STARVE_W'(LIMIT);

  logic [SPI_STARVE_W-1:0] count;

  // Clear has priority over increment so a grant edge always restarts the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_V)) begin
      count <= count + SPI_STARVE_W'(1);
    end
  end

  assign flag = (count == LIMIT_V);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Registered request/grant arbiter sharing one SPI bus between the memory
// controller and the peripheral engine, with a forced idle gap between owners.
module spi_bus_arbiter
  import spi_bus_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = SPI_GAP_DEFAULT,
  parameter int unsigned STARVE_LIMIT = SPI_STARVE_DEFAULT,
  parameter int unsigned NUM_PCS      = SPI_NUM_PCS,
  parameter logic        CPOL         = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_req,
  output logic               mem_gnt,
  input  logic               mem_sclk,
  input  logic               mem_mosi,
  input  logic               mem_cs_ram_n,
  input  logic               mem_cs_flash_n,
  input  logic               periph_req,
  output logic               periph_gnt,
  input  logic               periph_sclk,
  input  logic               periph_mosi,
  input  logic [NUM_PCS-1:0] periph_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  output logic               spi_cs_ram_n,
  output logic               spi_cs_flash_n,
  output logic [NUM_PCS-1:0] spi_periph_cs_n,
  output logic               bus_busy,
  output logic               starve_flag
);

  localparam logic [SPI_GAP_W-1:0] GAP_LOAD = SPI_GAP_W'(GAP_CYCLES - 1);

  arb_state_t           state;
  logic [SPI_GAP_W-1:0] gap_cnt;
  logic                 mem_win;
  logic                 periph_win;

  // Mem is preferred unless the peripheral has waited long enough to be starving.
  assign mem_win    = (state == ARB_IDLE) && mem_req && !(periph_req && starve_flag);
  assign periph_win = (state == ARB_IDLE) && periph_req && !mem_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      mem_gnt    <= 1'b0;
      periph_gnt <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (mem_win) begin
            state   <= ARB_OWN_MEM;
            mem_gnt <= 1'b1;
          end else if (periph_win) begin
            state      <= ARB_OWN_PERIPH;
            periph_gnt <= 1'b1;
          end
        end
        ARB_OWN_MEM: begin
          if (!mem_req) begin
            state   <= ARB_GAP;
            mem_gnt <= 1'b0;
            gap_cnt <= GAP_LOAD;
          end
        end
        ARB_OWN_PERIPH: begin
          if (!periph_req) begin
            state      <= ARB_GAP;
            periph_gnt <= 1'b0;
            gap_cnt    <= GAP_LOAD;
          end
        end
        ARB_GAP: begin
          if (gap_cnt == '0) begin
            state <= ARB_IDLE;
          end else begin
            gap_cnt <= gap_cnt - SPI_GAP_W'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  spi_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (periph_req && !periph_gnt),
    .clr   (!periph_req || periph_win),
    .flag  (starve_flag)
  );

  // Bus mux: only the registered owner reaches the pins; everyone else is masked idle.
  always_comb begin
    spi_sclk        = CPOL;
    spi_mosi        = 1'b0;
    spi_cs_ram_n    = 1'b1;
    spi_cs_flash_n  = 1'b1;
    spi_periph_cs_n = '1;
    case (state)
      ARB_OWN_MEM: begin
        spi_sclk       = mem_sclk;
        spi_mosi       = mem_mosi;
        spi_cs_ram_n   = mem_cs_ram_n;
        spi_cs_flash_n = mem_cs_flash_n;
      end
      ARB_OWN_PERIPH: begin
        spi_sclk        = periph_sclk;
        spi_mosi        = periph_mosi;
        spi_periph_cs_n = periph_cs_n;
      end
      default: begin
      end
    endcase
  end

  assign bus_busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench: a cycle model predicts outputs at each drive, the queue is
// drained and compared after every clock edge.
module tb_spi_bus_arbiter;

  localparam int unsigned GAP = 2;
  localparam int unsigned SL  = 8;
  localparam int unsigned NP  = 6;
  localparam logic        CP  = 1'b0;

  logic clk = 1'b0;
  logic reset, mem_req, mem_sclk, mem_mosi, mem_cs_ram_n, mem_cs_flash_n;
  logic periph_req, periph_sclk, periph_mosi;
  logic [NP-1:0] periph_cs_n;
  logic mem_gnt, periph_gnt, spi_sclk, spi_mosi, spi_cs_ram_n, spi_cs_flash_n;
  logic [NP-1:0] spi_periph_cs_n;
  logic bus_busy, starve_flag;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .GAP_CYCLES(GAP), .STARVE_LIMIT(SL), .NUM_PCS(NP), .CPOL(CP)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_sclk(mem_sclk), .mem_mosi(mem_mosi),
    .mem_cs_ram_n(mem_cs_ram_n), .mem_cs_flash_n(mem_cs_flash_n),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_sclk(periph_sclk),
    .periph_mosi(periph_mosi), .periph_cs_n(periph_cs_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_ram_n(spi_cs_ram_n),
    .spi_cs_flash_n(spi_cs_flash_n), .spi_periph_cs_n(spi_periph_cs_n),
    .bus_busy(bus_busy), .starve_flag(starve_flag)
  );

  typedef struct packed {
    logic          mg;
    logic          pg;
    logic          sclk;
    logic          mosi;
    logic          ram;
    logic          flash;
    logic [NP-1:0] pcs;
    logic          busy;
    logic          starve;
  } exp_t;

  exp_t q[$];

  // Reference model: 0 idle, 1 mem owns, 2 periph owns, 3 gap
  int m_state  = 0;
  int m_gap    = 0;
  int m_starve = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pgrant = 1'b0;
    bit pg_old = (m_state == 2);
    if (reset) begin
      m_state  = 0;
      m_gap    = 0;
      m_starve = 0;
    end else begin
      case (m_state)
        0: begin
          if (mem_req && !(periph_req && m_starve == int'(SL))) m_state = 1;
          else if (periph_req) begin
            m_state = 2;
            pgrant  = 1'b1;
          end
        end
        1: if (!mem_req) begin m_state = 3; m_gap = int'(GAP) - 1; end
        2: if (!periph_req) begin m_state = 3; m_gap = int'(GAP) - 1; end
        default: begin
          if (m_gap == 0) m_state = 0;
          else m_gap--;
        end
      endcase
      if (!periph_req || pgrant) m_starve = 0;
      else if (!pg_old && m_starve < int'(SL)) m_starve++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mg     = (m_state == 1);
    e.pg     = (m_state == 2);
    e.busy   = (m_state != 0);
    e.starve = (m_starve == int'(SL));
    e.sclk   = CP;
    e.mosi   = 1'b0;
    e.ram    = 1'b1;
    e.flash  = 1'b1;
    e.pcs    = '1;
    if (m_state == 1) begin
      e.sclk  = mem_sclk;
      e.mosi  = mem_mosi;
      e.ram   = mem_cs_ram_n;
      e.flash = mem_cs_flash_n;
    end else if (m_state == 2) begin
      e.sclk = periph_sclk;
      e.mosi = periph_mosi;
      e.pcs  = periph_cs_n;
    end
    return e;
  endfunction

  // One clock: predict, push, advance, pop and compare.
  task automatic tick();
    exp_t e;
    model_step();
    q.push_back(model_out());
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("gnt", 32'({mem_gnt, periph_gnt}), 32'({e.mg, e.pg}));
    check("bus", 32'({spi_sclk, spi_mosi, spi_cs_ram_n, spi_cs_flash_n, spi_periph_cs_n}),
          32'({e.sclk, e.mosi, e.ram, e.flash, e.pcs}));
    check("busy", 32'(bus_busy), 32'(e.busy));
    check("starve", 32'(starve_flag), 32'(e.starve));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pg_seen;
    reset = 1'b1; mem_req = 1'b0; mem_sclk = 1'b0; mem_mosi = 1'b0;
    mem_cs_ram_n = 1'b1; mem_cs_flash_n = 1'b1;
    periph_req = 1'b0; periph_sclk = 1'b1; periph_mosi = 1'b1; periph_cs_n = '0;

    // Reset and idle: bus must stay at idle levels even with periph driving CS low
    ticks(2);
    reset = 1'b0;
    ticks(10);
    check("idle_pcs", 32'(spi_periph_cs_n), 32'h3F);

    // Mem-only transaction with toggling pins; periph CS inputs held low stay masked
    mem_req = 1'b1;
    tick();
    check("mem_lat", 32'(mem_gnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      mem_sclk       = 1'(i);
      mem_mosi       = 1'($urandom_range(1));
      mem_cs_ram_n   = 1'(i == 7);
      mem_cs_flash_n = 1'b1;
      tick();
    end
    check("mem_mask_pcs", 32'(spi_periph_cs_n), 32'h3F);
    mem_req = 1'b0;
    periph_cs_n = '1;
    ticks(4);

    // Simultaneous requests: mem first, periph after the gap
    mem_req = 1'b1; periph_req = 1'b1;
    tick();
    check("tie_mem", 32'({mem_gnt, periph_gnt}), 32'b10);
    ticks(3);
    mem_req = 1'b0;
    tick();
    n = 0;
    while (!periph_gnt && n < 10) begin
      if (bus_busy) check("gap_cs", 32'({spi_cs_ram_n, spi_cs_flash_n, spi_periph_cs_n}), 32'hFF);
      tick();
      n++;
    end
    check("gap_lat", 32'(n), 32'(GAP + 1));
    periph_req = 1'b0;
    ticks(5);

    // Starvation: flag after SL waiting cycles, then periph beats a pending mem
    mem_req = 1'b1; periph_req = 1'b1;
    tick();
    n = 1;
    while (!starve_flag && n < 20) begin
      tick();
      n++;
    end
    check("starve_cycles", 32'(n), 32'(SL));
    mem_req = 1'b0;
    tick();
    mem_req = 1'b1;
    n = 0;
    while (!periph_gnt && n < 10) begin
      tick();
      n++;
    end
    check("starve_win", 32'({mem_gnt, periph_gnt}), 32'b01);
    check("starve_clr", 32'(starve_flag), 32'd0);
    ticks(2);
    periph_req = 1'b0;
    ticks(6);
    mem_req = 1'b0;
    ticks(5);

    // Periph pulse while mem owns: never granted, counter back to zero
    mem_req = 1'b1;
    ticks(2);
    periph_req = 1'b1;
    tick();
    periph_req = 1'b0;
    pg_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (periph_gnt) pg_seen++;
    end
    mem_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (periph_gnt) pg_seen++;
    end
    check("pulse_nognt", 32'(pg_seen), 32'd0);

    // Reset mid periph transaction
    periph_req = 1'b1;
    periph_cs_n = 6'h37;
    ticks(3);
    check("per_cs", 32'(spi_periph_cs_n), 32'h37);
    reset = 1'b1;
    tick();
    check("rst_mid", 32'({periph_gnt, bus_busy, spi_periph_cs_n}), 32'h3F);
    reset = 1'b0; periph_req = 1'b0; periph_cs_n = '1;
    ticks(3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) mem_req = ~mem_req;
      if ($urandom_range(7) == 0) periph_req = ~periph_req;
      reset          = 1'($urandom_range(99) == 0);
      mem_sclk       = 1'($urandom_range(1));
      mem_mosi       = 1'($urandom_range(1));
      mem_cs_ram_n   = 1'($urandom_range(1));
      mem_cs_flash_n = 1'($urandom_range(1));
      periph_sclk    = 1'($urandom_range(1));
      periph_mosi    = 1'($urandom_range(1));
      periph_cs_n    = NP'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
